// File: rtl/sdram_host_arbiter_pkg.sv
// Shared definitions for the SDRAM host-port arbiter: state encoding and
// default widths/timeouts that match the controller's host interface.
package sdram_host_pkg;

  localparam int HADDR_WIDTH_DEF   = 24;  // bank(2) + row(13) + col(9)
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int ISSUE_TIMEOUT_DEF = 64;  // longer than controller init (~45) and refresh (~15)

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_host_arbiter_rr.sv
// Round-robin picker: combinational one-hot grant from the request vector,
// searching from a registered pointer that moves past the winner on adv_i.
module rr_arbiter
  import sdram_host_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  always_comb begin
    int            pos;
    logic [IW-1:0] pos_idx;
    pos     = 0;
    pos_idx = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = 0; off < N; off++) begin
      pos = int'(ptr_q) + off;
      if (pos >= N) pos = pos - N;
      pos_idx = IW'(pos);
      if (!any_o && req_i[pos_idx]) begin
        any_o            = 1'b1;
        grant_o[pos_idx] = 1'b1;
        idx_o            = pos_idx;
      end
    end
  end

  assign ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Shares the single-command SDRAM controller host port among NUM_PORTS requesters,
// one command in flight, with a registered per-port completion/error pulse.
module sdram_host_arbiter
  import sdram_host_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int HADDR_WIDTH   = HADDR_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic                             resp_err,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic [HADDR_WIDTH-1:0]           sd_wr_addr,
  output logic [HADDR_WIDTH-1:0]           sd_rd_addr,
  output logic [DATA_WIDTH-1:0]            sd_wr_data,
  output logic                             sd_wr_enable,
  output logic                             sd_rd_enable,
  input  logic                             sd_busy,
  input  logic [DATA_WIDTH-1:0]            sd_rd_data,
  input  logic                             sd_rd_ready
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(ISSUE_TIMEOUT);
  localparam logic [NUM_PORTS-1:0] PORT0 = NUM_PORTS'(1);

  arb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          port_q, port_d;
  logic                   we_q, we_d;
  logic [HADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   got_q, got_d;
  logic                   idle_q, idle_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]   rvld_q, rvld_d;
  logic                   rerr_q, rerr_d;

  logic                   grant_fire;
  logic                   wr_en, rd_en;
  logic [NUM_PORTS-1:0]   rr_grant;
  logic [PW-1:0]          rr_idx;
  logic                   rr_any;

  rr_arbiter #(.N(NUM_PORTS), .IW(PW)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_valid),
    .adv_i  (grant_fire),
    .grant_o(rr_grant),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    got_d      = got_q;
    idle_d     = idle_q;
    rdata_d    = rdata_q;
    rvld_d     = '0;
    rerr_d     = 1'b0;
    grant_fire = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (rst_n && !sd_busy && rr_any) begin
          grant_fire = 1'b1;
          port_d     = rr_idx;
          we_d       = req_we[rr_idx];
          addr_d     = req_addr[int'(rr_idx)*HADDR_WIDTH +: HADDR_WIDTH];
          wdata_d    = req_wdata[int'(rr_idx)*DATA_WIDTH +: DATA_WIDTH];
          cnt_d      = '0;
          got_d      = 1'b0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Enable drops the same cycle busy is seen; it is held through refresh/init.
        if (sd_busy) begin
          state_d = ST_ACTIVE;
        end else begin
          wr_en = rst_n & we_q;
          rd_en = rst_n & ~we_q;
          if (cnt_q == CW'(ISSUE_TIMEOUT - 1)) begin
            rvld_d  = PORT0 << port_q;
            rerr_d  = 1'b1;
            idle_d  = 1'b0;
            state_d = ST_RECOVER;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!we_q && sd_rd_ready) begin
          rdata_d = sd_rd_data;
          got_d   = 1'b1;
        end
        if (!sd_busy) begin
          rvld_d  = PORT0 << port_q;
          rerr_d  = ~we_q & ~(got_q | sd_rd_ready);
          state_d = ST_ARB;
        end
      end
      ST_RECOVER: begin
        // Two idle cycles in a row rule out a command accepted on the timeout edge.
        idle_d = ~sd_busy;
        if (!sd_busy && idle_q) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      cnt_q   <= '0;
      port_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      got_q   <= 1'b0;
      idle_q  <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      got_q   <= got_d;
      idle_q  <= idle_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      rerr_q  <= rerr_d;
    end
  end

  assign req_ready    = grant_fire ? rr_grant : '0;
  assign resp_valid   = rvld_q;
  assign resp_err     = rerr_q;
  assign resp_rdata   = rdata_q;
  assign sd_wr_addr   = addr_q;
  assign sd_rd_addr   = addr_q;
  assign sd_wr_data   = wdata_q;
  assign sd_wr_enable = wr_en;
  assign sd_rd_enable = rd_en;

endmodule
